// File: rtl/regfile_ctrl.sv
// Sequencer/arbiter in front of a synchronous-read register file: clears every entry after
// reset, then shares the write port and rs read port between the pipeline and a debug requester.
module regfile_ctrl #(
  parameter int                NUM_REGS     = 32,
  parameter int                ADDR_W       = 5,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = {DATA_W{1'b0}},
  parameter bit                ZERO_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] pipe_rs_addr,
  input  logic [ADDR_W-1:0] pipe_rt_addr,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] rf_rs_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic [ADDR_W-1:0] rf_rs_addr,
  output logic [ADDR_W-1:0] rf_rt_addr,
  output logic              stall,
  output logic              busy,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_RUN      = 3'd1,
    S_DBG_WAIT = 3'd2,
    S_DBG_RD   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [DATA_W-1:0]   dbg_rdata_r;

  // A write may proceed unless it targets the protected zero register.
  function automatic logic write_allowed(input logic [ADDR_W-1:0] addr);
    return !(ZERO_PROTECT && (addr == {ADDR_W{1'b0}}));
  endfunction

  // State, clear counter and captured debug read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_CLEAR;
      clr_cnt_r   <= {ADDR_W{1'b0}};
      dbg_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == S_CLEAR) begin
        clr_cnt_r <= (clr_cnt_r == LAST_ADDR) ? {ADDR_W{1'b0}} : clr_cnt_r + ADDR_W'(1);
      end else begin
        clr_cnt_r <= clr_cnt_r;
      end
      if (state_r == S_DBG_RD) begin
        dbg_rdata_r <= rf_rs_data;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

  // Next state and register-file port steering; writebacks pass through by default.
  always_comb begin
    state_s     = state_r;
    rf_write_en = 1'b0;
    rf_rd_addr  = wb_addr;
    rf_rd_data  = wb_data;
    rf_rs_addr  = pipe_rs_addr;
    stall       = 1'b1;
    busy        = 1'b0;
    dbg_ack     = 1'b0;
    case (state_r)
      S_CLEAR: begin
        busy        = 1'b1;
        rf_write_en = 1'b1;
        rf_rd_addr  = clr_cnt_r;
        rf_rd_data  = CLEAR_VALUE;
        if (clr_cnt_r == LAST_ADDR) begin
          state_s = S_RUN;
        end else begin
          state_s = S_CLEAR;
        end
      end
      S_RUN: begin
        stall       = 1'b0;
        rf_write_en = wb_en & write_allowed(wb_addr);
        if (dbg_req) begin
          state_s = S_DBG_WAIT;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DBG_WAIT: begin
        if (wb_en) begin
          rf_write_en = write_allowed(wb_addr);
          state_s     = S_DBG_WAIT;
        end else if (dbg_we) begin
          rf_write_en = write_allowed(dbg_addr);
          rf_rd_addr  = dbg_addr;
          rf_rd_data  = dbg_wdata;
          state_s     = S_DONE;
        end else begin
          rf_rs_addr = dbg_addr;
          state_s    = S_DBG_RD;
        end
      end
      S_DBG_RD: begin
        rf_write_en = wb_en & write_allowed(wb_addr);
        state_s     = S_DONE;
      end
      S_DONE: begin
        // rs is re-driven here so pipeline read data is fresh once stall drops
        rf_write_en = wb_en & write_allowed(wb_addr);
        dbg_ack     = 1'b1;
        state_s     = S_RUN;
      end
      default: begin
        state_s = S_CLEAR;
      end
    endcase
  end

  assign rf_rt_addr = pipe_rt_addr;
  assign dbg_rdata  = dbg_rdata_r;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: models the register file, keeps an expected-contents array and
// checks clear, pass-through, debug latency/data and reset abort with directed and random steps.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [4:0]  pipe_rs_addr = 5'd0;
  logic [4:0]  pipe_rt_addr = 5'd0;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_wdata = 32'd0;
  logic [31:0] rf_rs_data;
  logic        rf_write_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [4:0]  rf_rs_addr;
  logic [4:0]  rf_rt_addr;
  logic        stall;
  logic        busy;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  logic        scramble = 1'b1;
  logic [31:0] mem [32];
  logic [31:0] ref_regs [32];
  int          n_assert = 0;
  int          n_fail = 0;

  regfile_ctrl dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pipe_rs_addr(pipe_rs_addr), .pipe_rt_addr(pipe_rt_addr), .dbg_req(dbg_req),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .rf_rs_data(rf_rs_data),
    .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr), .stall(stall), .busy(busy),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file; garbage is loaded at start so the clear is observable.
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_rd_addr] <= rf_rd_data;
    if (scramble) for (int i = 0; i < 32; i++) mem[i] <= $urandom;
    rf_rs_data <= mem[rf_rs_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after reset is released: expects one clear write per register.
  task automatic run_clear();
    for (int i = 0; i < 32; i++) begin
      chk("clr_we", 32'(rf_write_en), 32'd1);
      chk("clr_addr", 32'(rf_rd_addr), 32'(i));
      chk("clr_data", rf_rd_data, 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("post_clr_busy", 32'(busy), 32'd0);
    chk("post_clr_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    pipe_rt_addr = 5'($urandom); pipe_rs_addr = 5'($urandom);
    #1;
    chk("run_wb_we", 32'(rf_write_en), 32'(a != 5'd0));
    chk("run_wb_addr", 32'(rf_rd_addr), 32'(a));
    chk("rt_pass", 32'(rf_rt_addr), 32'(pipe_rt_addr));
    chk("rs_pass", 32'(rf_rs_addr), 32'(pipe_rs_addr));
    if (a != 5'd0) ref_regs[a] = d;
    tick();
    wb_en = 1'b0;
  endtask

  // Full debug access from RUN, with n_wb contending writebacks while waiting.
  task automatic dbg_op(input logic we, input logic [4:0] a, input logic [31:0] wd, input int n_wb);
    int cycles;
    logic got;
    logic [4:0] wa;
    logic [31:0] wdat;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; wb_en = 1'b0;
    #1;
    chk("req_stall_run", 32'(stall), 32'd0);
    tick();
    cycles = 1;
    for (int k = 0; k < n_wb; k++) begin
      wa = 5'($urandom_range(1, 31)); wdat = $urandom;
      wb_en = 1'b1; wb_addr = wa; wb_data = wdat;
      #1;
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_wb_we", 32'(rf_write_en), 32'd1);
      chk("wait_wb_addr", 32'(rf_rd_addr), 32'(wa));
      ref_regs[wa] = wdat;
      tick();
      cycles++;
    end
    wb_en = 1'b0;
    #1;
    chk("op_stall", 32'(stall), 32'd1);
    if (we) begin
      chk("dbgw_we", 32'(rf_write_en), 32'(a != 5'd0));
      chk("dbgw_addr", 32'(rf_rd_addr), 32'(a));
      chk("dbgw_data", rf_rd_data, wd);
      if (a != 5'd0) ref_regs[a] = wd;
    end else begin
      chk("dbgr_rs", 32'(rf_rs_addr), 32'(a));
      chk("dbgr_we", 32'(rf_write_en), 32'd0);
    end
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      cycles++;
      chk("busy_stall", 32'(stall), 32'd1);
      if (dbg_ack) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(cycles), 32'((we ? 2 : 3) + n_wb));
    if (!we) chk("dbg_rdata", dbg_rdata, ref_regs[a]);
    dbg_req = 1'b0;
    tick();
    chk("ack_pulse", 32'(dbg_ack), 32'd0);
    chk("stall_release", 32'(stall), 32'd0);
  endtask

  initial begin
    // T1: reset state, then clear
    tick();
    scramble = 1'b0;
    tick();
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_we", 32'(rf_write_en), 32'd1);
    chk("rst_addr", 32'(rf_rd_addr), 32'd0);
    reset = 1'b1;
    run_clear();
    dbg_op(1'b0, 5'd5, 32'd0, 0);

    // T2: writeback then debug read
    wb_write(5'd7, 32'hDEADBEEF);
    dbg_op(1'b0, 5'd7, 32'd0, 0);
    chk("t2_value", dbg_rdata, 32'hDEADBEEF);

    // T3: debug write delayed by three writebacks
    dbg_op(1'b1, 5'd3, 32'h12345678, 3);
    dbg_op(1'b0, 5'd3, 32'd0, 0);
    chk("t3_value", dbg_rdata, 32'h12345678);

    // T4: address-0 protection
    wb_write(5'd0, 32'hFFFFFFFF);
    dbg_op(1'b1, 5'd0, 32'hFFFFFFFF, 0);
    dbg_op(1'b0, 5'd0, 32'd0, 0);
    chk("t4_zero", dbg_rdata, 32'd0);

    // Randomized traffic against the expected-contents model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: wb_write(5'($urandom), $urandom);
        1: dbg_op(1'b1, 5'($urandom), $urandom, int'($urandom_range(0, 2)));
        default: dbg_op(1'b0, 5'($urandom), 32'd0, int'($urandom_range(0, 2)));
      endcase
    end

    // T6: dbg_req held across two reads
    wb_write(5'd1, 32'hA5A5_0001);
    wb_write(5'd2, 32'h5A5A_0002);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd1;
    tick(); tick(); tick();
    chk("t6_ack1", 32'(dbg_ack), 32'd1);
    chk("t6_data1", dbg_rdata, ref_regs[1]);
    dbg_addr = 5'd2;
    tick();
    chk("t6_gap_stall", 32'(stall), 32'd0);
    chk("t6_gap_ack", 32'(dbg_ack), 32'd0);
    tick();
    chk("t6_restall", 32'(stall), 32'd1);
    tick(); tick();
    chk("t6_ack2", 32'(dbg_ack), 32'd1);
    chk("t6_data2", dbg_rdata, ref_regs[2]);
    dbg_req = 1'b0;
    tick();
    chk("t6_end_stall", 32'(stall), 32'd0);

    // T5: reset during DBG_RD aborts the read and restarts the clear
    wb_write(5'd9, 32'hCAFEF00D);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    tick(); tick();
    chk("t5_rd_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_stall", 32'(stall), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_ack", 32'(dbg_ack), 32'd0);
    chk("t5_addr", 32'(rf_rd_addr), 32'd0);
    dbg_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_ack", 32'(dbg_ack), 32'd0);
    end
    reset = 1'b1;
    run_clear();
    dbg_op(1'b0, 5'd9, 32'd0, 0);
    chk("t5_cleared", dbg_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
